// File: rtl/dm_pkg.sv
// Shared definitions for the debug-module abstract-command controller:
// DMI address map, cmderr/cmdtype encodings and register field positions.
package dm_pkg;

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;
  localparam logic [6:0] ADDR_PROGBUF0   = 7'h20;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4,
    CMDERR_BUS        = 3'd5
  } cmderr_e;

  // Must match the core's debug header.
  localparam logic [7:0] CMD_ACCESS_REG   = 8'd0;
  localparam logic [7:0] CMD_QUICK_ACCESS = 8'd1;
  localparam logic [7:0] CMD_ACCESS_MEM   = 8'd2;

  typedef enum logic {CMD_IDLE, CMD_BUSY} cmd_state_e;

  localparam int DMCONTROL_HALTREQ   = 31;
  localparam int DMCONTROL_RESUMEREQ = 30;
  localparam int DMCONTROL_NDMRESET  = 1;
  localparam int DMCONTROL_DMACTIVE  = 0;

  localparam int DMSTATUS_IMPEBREAK     = 22;
  localparam int DMSTATUS_ALLRESUMEACK  = 17;
  localparam int DMSTATUS_ANYRESUMEACK  = 16;
  localparam int DMSTATUS_ALLRUNNING    = 11;
  localparam int DMSTATUS_ANYRUNNING    = 10;
  localparam int DMSTATUS_ALLHALTED     = 9;
  localparam int DMSTATUS_ANYHALTED     = 8;
  localparam int DMSTATUS_AUTHENTICATED = 7;
  localparam logic [3:0] DM_VERSION     = 4'd2;

  localparam int ABSTRACTCS_PROGBUFSIZE_LSB = 24;
  localparam int ABSTRACTCS_BUSY            = 12;
  localparam int ABSTRACTCS_CMDERR_LSB      = 8;
  localparam int COMMAND_CMDTYPE_LSB        = 24;

endpackage

// File: rtl/dm_abstract_ctl_if.sv
// DMI access bus between the debug transport and the debug module.
interface dm_abstract_ctl_if;
  logic        dmi_req;
  logic        dmi_we;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;
  logic        dmi_ack;

  modport master (output dmi_req, dmi_we, dmi_addr, dmi_wdata, input dmi_rdata, dmi_ack);
  modport slave  (input dmi_req, dmi_we, dmi_addr, dmi_wdata, output dmi_rdata, dmi_ack);
endinterface

// File: rtl/dm_dmi_regs.sv
// data0/progbuf storage plus the registered DMI read mux and ack.
module dm_dmi_regs
  import dm_pkg::*;
#(
  parameter int PROGBUF_SIZE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      buf_wr_en,
  input  logic                      dmi_req,
  input  logic                      dmi_we,
  input  logic [6:0]                dmi_addr,
  input  logic [31:0]               dmi_wdata,
  input  logic                      core_write,
  input  logic [31:0]               core_wdata,
  input  logic                      rd_enable,
  input  logic [31:0]               rd_dmcontrol,
  input  logic [31:0]               rd_dmstatus,
  input  logic [31:0]               rd_abstractcs,
  output logic [31:0]               data0,
  output logic [32*PROGBUF_SIZE-1:0] progbuf,
  output logic [31:0]               dmi_rdata,
  output logic                      dmi_ack
);

  logic [31:0] data0_q, data0_d;
  logic [31:0] progbuf_q [PROGBUF_SIZE];
  logic [31:0] progbuf_d [PROGBUF_SIZE];
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic        ack_q, ack_d;
  logic        buf_wr;

  assign buf_wr = dmi_req && dmi_we && buf_wr_en;

  always_comb begin
    data0_d   = data0_q;
    progbuf_d = progbuf_q;
    if (buf_wr && dmi_addr == ADDR_DATA0) data0_d = dmi_wdata;
    for (int i = 0; i < PROGBUF_SIZE; i++) begin
      if (buf_wr && dmi_addr == ADDR_PROGBUF0 + 7'(i)) progbuf_d[i] = dmi_wdata;
    end
    // The core's transfer result wins over a same-cycle DMI write.
    if (core_write) data0_d = core_wdata;
    if (clear) begin
      data0_d = '0;
      for (int i = 0; i < PROGBUF_SIZE; i++) progbuf_d[i] = '0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (dmi_addr)
      ADDR_DATA0:      rd_val = data0_q;
      ADDR_DMCONTROL:  rd_val = rd_dmcontrol;
      ADDR_DMSTATUS:   rd_val = rd_dmstatus;
      ADDR_ABSTRACTCS: rd_val = rd_abstractcs;
      default:         rd_val = '0;
    endcase
    for (int i = 0; i < PROGBUF_SIZE; i++) begin
      if (dmi_addr == ADDR_PROGBUF0 + 7'(i)) rd_val = progbuf_q[i];
    end
    if (!rd_enable) rd_val = '0;
    ack_d   = dmi_req;
    rdata_d = rdata_q;
    if (dmi_req) rdata_d = dmi_we ? '0 : rd_val;
  end

  // NOTE: progbuf is a handful of flops, not a RAM, so it is reset like any
  // other register; the core may fetch it before the debugger ever writes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0_q <= '0;
      for (int i = 0; i < PROGBUF_SIZE; i++) progbuf_q[i] <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      data0_q   <= data0_d;
      progbuf_q <= progbuf_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
    end
  end

  for (genvar g = 0; g < PROGBUF_SIZE; g++) begin : g_pb
    assign progbuf[32*g +: 32] = progbuf_q[g];
  end

  assign data0     = data0_q;
  assign dmi_rdata = rdata_q;
  assign dmi_ack   = ack_q;

endmodule

// File: rtl/dm_abstract_ctl.sv
// Debug-module control: dmcontrol/halt/resume handling, abstract command FSM
// and cmderr tracking; register storage and read mux live in dm_dmi_regs.
module dm_abstract_ctl
  import dm_pkg::*;
#(
  parameter int PROGBUF_SIZE = 2,
  parameter int DATA_COUNT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  dm_abstract_ctl_if.slave           dmi,
  output logic                       halt_req,
  output logic                       resume_req,
  output logic                       exec,
  output logic [31:0]                command,
  output logic [31:0]                data0,
  output logic [32*PROGBUF_SIZE-1:0] progbuf,
  output logic                       ndmreset,
  input  logic                       halted,
  input  logic                       done,
  input  logic                       write,
  input  logic [31:0]                wdata,
  input  logic                       exception,
  input  logic                       bus,
  input  logic                       haltresume
);

  cmd_state_e  state_q, state_d;
  cmderr_e     cmderr_q, cmderr_d;
  logic [31:0] command_q, command_d;
  logic        dmactive_q, dmactive_d;
  logic        haltreq_q, haltreq_d;
  logic        ndmreset_q, ndmreset_d;
  logic        resume_pend_q, resume_pend_d;
  logic        resumeack_q, resumeack_d;
  logic        busy, clear, dmi_wr, wr_buf;
  logic [7:0]  cmdtype;
  logic [31:0] rd_dmcontrol, rd_dmstatus, rd_abstractcs;

  assign busy    = (state_q == CMD_BUSY);
  assign dmi_wr  = dmi.dmi_req && dmi.dmi_we;
  assign cmdtype = dmi.dmi_wdata[COMMAND_CMDTYPE_LSB +: 8];
  assign wr_buf  = dmi_wr && (dmi.dmi_addr == ADDR_DATA0 ||
                   (dmi.dmi_addr >= ADDR_PROGBUF0 &&
                    dmi.dmi_addr < ADDR_PROGBUF0 + 7'(PROGBUF_SIZE)));

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cmderr_d      = cmderr_q;
    command_d     = command_q;
    dmactive_d    = dmactive_q;
    haltreq_d     = haltreq_q;
    ndmreset_d    = ndmreset_q;
    resume_pend_d = resume_pend_q;
    resumeack_d   = resumeack_q;
    clear         = 1'b0;

    if (busy && done) begin
      state_d = CMD_IDLE;
      if (cmderr_q == CMDERR_NONE) begin
        if (exception)       cmderr_d = CMDERR_EXCEPTION;
        else if (bus)        cmderr_d = CMDERR_BUS;
        else if (haltresume) cmderr_d = CMDERR_HALTRESUME;
      end
    end

    if (resume_pend_q && !halted) begin
      resume_pend_d = 1'b0;
      resumeack_d   = 1'b1;
    end

    if (dmi_wr && dmi.dmi_addr == ADDR_DMCONTROL) begin
      dmactive_d = dmi.dmi_wdata[DMCONTROL_DMACTIVE];
      haltreq_d  = dmi.dmi_wdata[DMCONTROL_HALTREQ];
      ndmreset_d = dmi.dmi_wdata[DMCONTROL_NDMRESET];
      if (dmi.dmi_wdata[DMCONTROL_RESUMEREQ] && !dmi.dmi_wdata[DMCONTROL_HALTREQ]) begin
        resume_pend_d = 1'b1;
        resumeack_d   = 1'b0;
      end
    end

    if (dmi_wr && dmi.dmi_addr == ADDR_ABSTRACTCS)
      cmderr_d = cmderr_e'(cmderr_d & ~dmi.dmi_wdata[ABSTRACTCS_CMDERR_LSB +: 3]);

    if (dmi_wr && dmi.dmi_addr == ADDR_COMMAND) begin
      if (busy)                              cmderr_d = CMDERR_BUSY;
      else if (cmderr_q != CMDERR_NONE)      cmderr_d = cmderr_q;
      else if (cmdtype > CMD_ACCESS_MEM)     cmderr_d = CMDERR_NOTSUP;
      else if (cmdtype != CMD_QUICK_ACCESS && !halted) cmderr_d = CMDERR_HALTRESUME;
      else begin
        command_d = dmi.dmi_wdata;
        state_d   = CMD_BUSY;
      end
    end

    if (wr_buf && busy) cmderr_d = CMDERR_BUSY;

    // Inactive module, or one being deactivated this cycle: only dmactive survives.
    if (!dmactive_q || !dmactive_d) begin
      clear         = 1'b1;
      state_d       = CMD_IDLE;
      cmderr_d      = CMDERR_NONE;
      command_d     = '0;
      haltreq_d     = 1'b0;
      ndmreset_d    = 1'b0;
      resume_pend_d = 1'b0;
      resumeack_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CMD_IDLE;
      cmderr_q      <= CMDERR_NONE;
      command_q     <= '0;
      dmactive_q    <= 1'b0;
      haltreq_q     <= 1'b0;
      ndmreset_q    <= 1'b0;
      resume_pend_q <= 1'b0;
      resumeack_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmderr_q      <= cmderr_d;
      command_q     <= command_d;
      dmactive_q    <= dmactive_d;
      haltreq_q     <= haltreq_d;
      ndmreset_q    <= ndmreset_d;
      resume_pend_q <= resume_pend_d;
      resumeack_q   <= resumeack_d;
    end
  end

  always_comb begin
    rd_dmcontrol = '0;
    rd_dmcontrol[DMCONTROL_HALTREQ]  = haltreq_q;
    rd_dmcontrol[DMCONTROL_NDMRESET] = ndmreset_q;
    rd_dmcontrol[DMCONTROL_DMACTIVE] = dmactive_q;

    rd_dmstatus = '0;
    rd_dmstatus[DMSTATUS_IMPEBREAK]     = 1'b1;
    rd_dmstatus[DMSTATUS_ALLRESUMEACK]  = resumeack_q;
    rd_dmstatus[DMSTATUS_ANYRESUMEACK]  = resumeack_q;
    rd_dmstatus[DMSTATUS_ALLRUNNING]    = !halted;
    rd_dmstatus[DMSTATUS_ANYRUNNING]    = !halted;
    rd_dmstatus[DMSTATUS_ALLHALTED]     = halted;
    rd_dmstatus[DMSTATUS_ANYHALTED]     = halted;
    rd_dmstatus[DMSTATUS_AUTHENTICATED] = 1'b1;
    rd_dmstatus[3:0]                    = DM_VERSION;

    rd_abstractcs = '0;
    rd_abstractcs[ABSTRACTCS_PROGBUFSIZE_LSB +: 5] = 5'(PROGBUF_SIZE);
    rd_abstractcs[ABSTRACTCS_BUSY]                 = busy;
    rd_abstractcs[ABSTRACTCS_CMDERR_LSB +: 3]      = cmderr_q;
    rd_abstractcs[3:0]                             = 4'(DATA_COUNT);
  end

  dm_dmi_regs #(.PROGBUF_SIZE(PROGBUF_SIZE)) u_regs (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .buf_wr_en     (!busy),
    .dmi_req       (dmi.dmi_req),
    .dmi_we        (dmi.dmi_we),
    .dmi_addr      (dmi.dmi_addr),
    .dmi_wdata     (dmi.dmi_wdata),
    .core_write    (write),
    .core_wdata    (wdata),
    .rd_enable     (dmactive_q),
    .rd_dmcontrol  (rd_dmcontrol),
    .rd_dmstatus   (rd_dmstatus),
    .rd_abstractcs (rd_abstractcs),
    .data0         (data0),
    .progbuf       (progbuf),
    .dmi_rdata     (dmi.dmi_rdata),
    .dmi_ack       (dmi.dmi_ack)
  );

  assign halt_req   = haltreq_q;
  assign resume_req = resume_pend_q;
  assign exec       = busy;
  assign command    = command_q;
  assign ndmreset   = ndmreset_q;

endmodule

// File: tb/tb_dm_abstract_ctl.sv
// Self-checking bench for dm_abstract_ctl: directed scenarios followed by
// random DMI/core traffic compared against a transaction-level model.
module tb_dm_abstract_ctl;

  localparam int PB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_abstract_ctl_if dmi ();

  logic              halt_req, resume_req, exec, ndmreset;
  logic [31:0]       command, data0, core_wdata;
  logic [32*PB-1:0]  progbuf;
  logic              halted, done, write, exception, bus, haltresume;

  dm_abstract_ctl #(.PROGBUF_SIZE(PB), .DATA_COUNT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmi        (dmi),
    .halt_req   (halt_req),
    .resume_req (resume_req),
    .exec       (exec),
    .command    (command),
    .data0      (data0),
    .progbuf    (progbuf),
    .ndmreset   (ndmreset),
    .halted     (halted),
    .done       (done),
    .write      (write),
    .wdata      (core_wdata),
    .exception  (exception),
    .bus        (bus),
    .haltresume (haltresume)
  );

  // Reference model: architectural state of the debug module.
  bit          m_active, m_haltreq, m_ndmreset, m_pend, m_ack, m_busy, m_dmi_ack;
  logic [2:0]  m_cmderr;
  logic [31:0] m_cmd, m_data0, m_rdata;
  logic [31:0] m_pb [PB];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_haltreq = 0; m_ndmreset = 0; m_pend = 0; m_ack = 0; m_busy = 0;
    m_cmderr = '0; m_cmd = '0; m_data0 = '0;
    for (int i = 0; i < PB; i++) m_pb[i] = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_active = 0; m_dmi_ack = 0; m_rdata = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a);
    logic [31:0] v;
    v = '0;
    if (!m_active) return '0;
    if (a == 7'h04) v = m_data0;
    else if (a == 7'h10) v = {m_haltreq, 29'b0, m_ndmreset, 1'b1};
    else if (a == 7'h11) v = 32'h0040_0082 | (halted ? 32'h0000_0300 : 32'h0000_0C00)
                             | (m_ack ? 32'h0003_0000 : 32'h0);
    else if (a == 7'h16) v = (32'(PB) << 24) | (32'(m_busy) << 12) | (32'(m_cmderr) << 8) | 32'd1;
    else if (a >= 7'h20 && int'(a) < 32 + PB) v = m_pb[int'(a) - 32];
    return v;
  endfunction

  // Apply one clock edge worth of stimulus to the model.
  task automatic model_step();
    logic [31:0] w;
    logic [6:0]  a;
    bit          wr, busy0;
    logic [2:0]  err0;
    w = dmi.dmi_wdata; a = dmi.dmi_addr;
    wr = dmi.dmi_req && dmi.dmi_we;
    busy0 = m_busy; err0 = m_cmderr;
    if (dmi.dmi_req) m_rdata = dmi.dmi_we ? 32'h0 : model_read(a);
    m_dmi_ack = dmi.dmi_req;
    if (!m_active) begin
      if (wr && a == 7'h10) m_active = w[0];
      return;
    end
    if (wr && a == 7'h10 && !w[0]) begin
      m_active = 0;
      model_clear();
      return;
    end
    if (done && busy0) begin
      m_busy = 0;
      if (err0 == 0) m_cmderr = exception ? 3'd3 : bus ? 3'd5 : haltresume ? 3'd4 : 3'd0;
    end
    if (m_pend && !halted) begin m_pend = 0; m_ack = 1; end
    if (write) m_data0 = core_wdata;
    if (wr) begin
      if (a == 7'h10) begin
        m_haltreq = w[31]; m_ndmreset = w[1];
        if (w[30] && !w[31]) begin m_pend = 1; m_ack = 0; end
      end else if (a == 7'h16) begin
        m_cmderr = m_cmderr & ~w[10:8];
      end else if (a == 7'h17) begin
        if (busy0) m_cmderr = 3'd1;
        else if (err0 != 0) m_cmderr = err0;
        else if (w[31:24] > 8'd2) m_cmderr = 3'd2;
        else if (w[31:24] != 8'd1 && !halted) m_cmderr = 3'd4;
        else begin m_cmd = w; m_busy = 1; end
      end else if (a == 7'h04) begin
        if (busy0) m_cmderr = 3'd1;
        else if (!write) m_data0 = w;
      end else if (a >= 7'h20 && int'(a) < 32 + PB) begin
        if (busy0) m_cmderr = 3'd1;
        else m_pb[int'(a) - 32] = w;
      end
    end
  endtask

  task automatic compare_all();
    check("dmi_ack", {31'b0, dmi.dmi_ack}, {31'b0, m_dmi_ack});
    check("dmi_rdata", dmi.dmi_rdata, m_rdata);
    check("halt_req", {31'b0, halt_req}, {31'b0, m_haltreq});
    check("resume_req", {31'b0, resume_req}, {31'b0, m_pend});
    check("exec", {31'b0, exec}, {31'b0, m_busy});
    check("ndmreset", {31'b0, ndmreset}, {31'b0, m_ndmreset});
    check("command", command, m_cmd);
    check("data0", data0, m_data0);
    for (int i = 0; i < PB; i++) check("progbuf", progbuf[32*i +: 32], m_pb[i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    dmi.dmi_req = 0; dmi.dmi_we = 0; done = 0; write = 0;
    exception = 0; bus = 0; haltresume = 0;
  endtask

  task automatic dmi_write(input logic [6:0] a, input logic [31:0] v);
    dmi.dmi_req = 1; dmi.dmi_we = 1; dmi.dmi_addr = a; dmi.dmi_wdata = v;
    step();
  endtask

  task automatic dmi_read(input logic [6:0] a, output logic [31:0] d);
    dmi.dmi_req = 1; dmi.dmi_we = 0; dmi.dmi_addr = a; dmi.dmi_wdata = '0;
    step();
    d = dmi.dmi_rdata;
  endtask

  function automatic logic [31:0] rand_wdata(input logic [6:0] a);
    logic [31:0] v;
    logic [7:0]  types [5];
    types = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5};
    v = $urandom;
    if (a == 7'h10) begin
      v = '0;
      v[31] = 1'($urandom_range(1));
      v[30] = 1'($urandom_range(1));
      v[1]  = 1'($urandom_range(1));
      v[0]  = ($urandom_range(15) != 0);
    end else if (a == 7'h17) begin
      v[31:24] = types[$urandom_range(4)];
    end
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    logic [6:0]  addrs [10];
    addrs = '{7'h04, 7'h10, 7'h11, 7'h16, 7'h17, 7'h20, 7'h21, 7'h22, 7'h05, 7'h7F};

    rst = 1; halted = 0; done = 0; write = 0; core_wdata = '0;
    exception = 0; bus = 0; haltresume = 0;
    dmi.dmi_req = 0; dmi.dmi_we = 0; dmi.dmi_addr = '0; dmi.dmi_wdata = '0;
    model_reset();
    #12;
    check("rst_dmi_ack", {31'b0, dmi.dmi_ack}, 32'h0);
    check("rst_dmi_rdata", dmi.dmi_rdata, 32'h0);
    check("rst_halt_req", {31'b0, halt_req}, 32'h0);
    check("rst_resume_req", {31'b0, resume_req}, 32'h0);
    check("rst_exec", {31'b0, exec}, 32'h0);
    check("rst_ndmreset", {31'b0, ndmreset}, 32'h0);
    rst = 0;

    // Activate and halt.
    dmi_write(7'h10, 32'h0000_0001);
    dmi_write(7'h10, 32'h8000_0001);
    check("halt_req_set", {31'b0, halt_req}, 32'h1);
    halted = 1;
    dmi_read(7'h11, d);
    check("dmstatus_halted", d, 32'h0040_0382);

    // Accepted command, busy rejection, W1C, transfer and completion.
    dmi_write(7'h17, 32'h0022_1000);
    check("exec_rise", {31'b0, exec}, 32'h1);
    dmi_read(7'h16, d);
    check("busy_set", {31'b0, d[12]}, 32'h1);
    dmi_write(7'h17, 32'h0022_1001);
    dmi_read(7'h16, d);
    check("cmderr_busy", {29'b0, d[10:8]}, 32'h1);
    check("cmd_unchanged", command, 32'h0022_1000);
    dmi_write(7'h16, 32'h0000_0700);
    dmi_read(7'h16, d);
    check("cmderr_w1c", {29'b0, d[10:8]}, 32'h0);
    write = 1; core_wdata = 32'hDEAD_BEEF; step();
    done = 1; step();
    check("exec_fall", {31'b0, exec}, 32'h0);
    dmi_read(7'h04, d);
    check("data0_xfer", d, 32'hDEAD_BEEF);
    dmi_read(7'h16, d);
    check("abstractcs_idle", d, 32'h0200_0001);

    // Errors while running and unsupported cmdtype.
    halted = 0; step();
    dmi_write(7'h17, 32'h0022_1000);
    check("exec_running", {31'b0, exec}, 32'h0);
    dmi_read(7'h16, d);
    check("cmderr_haltresume", {29'b0, d[10:8]}, 32'h4);
    dmi_write(7'h16, 32'h0000_0700);
    dmi_write(7'h17, 32'h0500_0000);
    dmi_read(7'h16, d);
    check("cmderr_notsup", {29'b0, d[10:8]}, 32'h2);
    dmi_write(7'h16, 32'h0000_0700);

    // Resume handshake.
    halted = 1;
    dmi_write(7'h10, 32'h4000_0001);
    check("resume_req_set", {31'b0, resume_req}, 32'h1);
    check("halt_req_clr", {31'b0, halt_req}, 32'h0);
    halted = 0; step();
    check("resume_req_clr", {31'b0, resume_req}, 32'h0);
    dmi_read(7'h11, d);
    check("dmstatus_resumeack", d, 32'h0043_0C82);

    // Error priority on done.
    halted = 1; step();
    dmi_write(7'h17, 32'h0022_1000);
    done = 1; exception = 1; bus = 1; step();
    dmi_read(7'h16, d);
    check("cmderr_exception", {29'b0, d[10:8]}, 32'h3);
    dmi_write(7'h16, 32'h0000_0700);

    // Program buffer, unmapped and write-only reads, data0 write priority.
    dmi_write(7'h20, 32'hA5A5_0001);
    dmi_write(7'h21, 32'h1234_5678);
    dmi_write(7'h22, 32'hFFFF_FFFF);
    dmi_read(7'h21, d);
    check("progbuf1_read", d, 32'h1234_5678);
    dmi_read(7'h22, d);
    check("unmapped_read", d, 32'h0);
    dmi_read(7'h17, d);
    check("command_read_zero", d, 32'h0);
    write = 1; core_wdata = 32'h0BAD_F00D;
    dmi_write(7'h04, 32'h1111_2222);
    check("data0_core_priority", data0, 32'h0BAD_F00D);

    // Deactivate mid-command.
    dmi_write(7'h17, 32'h0022_1000);
    check("exec_before_deact", {31'b0, exec}, 32'h1);
    dmi_write(7'h10, 32'h0000_0000);
    check("exec_deact", {31'b0, exec}, 32'h0);
    dmi_read(7'h04, d);
    check("deact_data0", d, 32'h0);
    dmi_read(7'h16, d);
    check("deact_abstractcs", d, 32'h0);
    dmi_read(7'h11, d);
    check("deact_dmstatus", d, 32'h0);
    done = 1; exception = 1; step();
    dmi_write(7'h10, 32'h0000_0001);
    dmi_read(7'h16, d);
    check("late_done_ignored", d, 32'h0200_0001);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) halted = ~halted;
      if ($urandom_range(1) == 1) begin
        dmi.dmi_req   = 1;
        dmi.dmi_we    = 1'($urandom_range(1));
        dmi.dmi_addr  = addrs[$urandom_range(9)];
        dmi.dmi_wdata = rand_wdata(dmi.dmi_addr);
      end else if ($urandom_range(3) == 0) begin
        done       = 1;
        exception  = ($urandom_range(3) == 0);
        bus        = ($urandom_range(3) == 0);
        haltresume = ($urandom_range(3) == 0);
      end
      if ($urandom_range(7) == 0) begin
        write = 1; core_wdata = $urandom;
      end
      step();
    end

    // Asynchronous reset between edges.
    dmi_write(7'h10, 32'h0000_0001);
    dmi_write(7'h10, 32'h8000_0001);
    write = 1; core_wdata = 32'h1234_ABCD; step();
    #3 rst = 1;
    #1;
    check("arst_halt_req", {31'b0, halt_req}, 32'h0);
    check("arst_data0", data0, 32'h0);
    check("arst_exec", {31'b0, exec}, 32'h0);
    check("arst_dmi_ack", {31'b0, dmi.dmi_ack}, 32'h0);
    model_reset();
    #2 rst = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
